// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions for the stall/flush scheduler:
// FSM state encodings, the default data-memory timeout and the bundle of
// per-stage hold/bubble/flush controls.
package pipe_stall_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam int MEM_TIMEOUT_DEF = 64;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_stall;
      logic mem_wb_bubble;
   } stall_ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl_timeout.sv
// mem_timeout_cnt: wait-cycle counter for an outstanding data-memory access.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (count -> 0)
//   clr    synchronous clear, wins over en
//   en     count one more wait cycle
//   tc     count currently equals TERMINAL
module mem_timeout_cnt #(
   parameter int TO_W     = 7,
   parameter int TERMINAL = 63
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TERMINAL);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) cnt <= '0;
      else if (en)       cnt <= cnt + TO_W'(1);
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Merges the load-use stall, the ID branch flush and multi-cycle data-memory
// accesses into per-stage hold/bubble/flush controls, and runs the memory
// request/ack handshake with a timeout into a sticky error state.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   hd_stall_i, branch_taken_i            hazard / branch requests
//   mem_rd_i, mem_wr_i, mem_ack_i         MEM-stage access and memory ack
//   mem_req_o, mem_we_o, mem_err_o        registered memory outputs
//   pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
//   ex_mem_stall_o, mem_wb_bubble_o       combinational stage controls
//   stall_cnt_o                           PC-stall cycle counter
// Build option: define PIPE_STALL_CNT_EN to add the saturating stall_cnt_o.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int TO_W        = 7
`ifdef PIPE_STALL_CNT_EN
   , parameter int CNT_W     = 32
`endif
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic hd_stall_i,
   input  logic branch_taken_i,
   input  logic mem_rd_i,
   input  logic mem_wr_i,
   input  logic mem_ack_i,
   output logic mem_req_o,
   output logic mem_we_o,
   output logic pc_stall_o,
   output logic if_id_stall_o,
   output logic if_id_flush_o,
   output logic id_ex_bubble_o,
   output logic ex_mem_stall_o,
   output logic mem_wb_bubble_o,
   output logic mem_err_o
`ifdef PIPE_STALL_CNT_EN
   , output logic [CNT_W-1:0] stall_cnt_o
`endif
);

   logic [1:0]  state, state_nxt;
   logic        in_idle, in_wait, in_err;
   logic        mem_acc, mem_stall, to_tc;
   stall_ctrl_t ctrl;

   assign in_idle = (state == ST_IDLE);
   assign in_wait = (state == ST_WAIT);
   assign in_err  = (state == ST_ERR);
   assign mem_acc = mem_rd_i | mem_wr_i;

   // An ack in WAIT releases the pipe in the same cycle so MEM/WB captures
   // the returned data; ERR freezes everything until reset.
   assign mem_stall = (in_idle & mem_acc) | (in_wait & ~mem_ack_i) | in_err;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (mem_acc) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (mem_ack_i)  state_nxt = ST_IDLE;  // ack beats timeout
            else if (to_tc) state_nxt = ST_ERR;
         end
         ST_ERR:  state_nxt = ST_ERR;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Memory stall freezes ID rather than bubbling it, so a pending hazard or
   // branch simply re-presents once the access completes.
   always_comb begin
      ctrl = '0;
      if (rst_i) begin
         if (mem_stall) begin
            ctrl.pc_stall      = 1'b1;
            ctrl.if_id_stall   = 1'b1;
            ctrl.ex_mem_stall  = 1'b1;
            ctrl.mem_wb_bubble = 1'b1;
         end else if (hd_stall_i) begin
            ctrl.pc_stall      = 1'b1;
            ctrl.if_id_stall   = 1'b1;
            ctrl.id_ex_bubble  = 1'b1;
         end else if (branch_taken_i) begin
            ctrl.if_id_flush   = 1'b1;
         end
      end
   end

   assign pc_stall_o      = ctrl.pc_stall;
   assign if_id_stall_o   = ctrl.if_id_stall;
   assign if_id_flush_o   = ctrl.if_id_flush;
   assign id_ex_bubble_o  = ctrl.id_ex_bubble;
   assign ex_mem_stall_o  = ctrl.ex_mem_stall;
   assign mem_wb_bubble_o = ctrl.mem_wb_bubble;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         mem_req_o <= 1'b0;
         mem_we_o  <= 1'b0;
         mem_err_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         mem_req_o <= (state_nxt == ST_WAIT);
         // Direction is latched on entry; a store wins if both rd and wr set.
         mem_we_o  <= (state_nxt == ST_WAIT) & (in_idle ? mem_wr_i : mem_we_o);
         mem_err_o <= mem_err_o | (state_nxt == ST_ERR);
      end
   end

   mem_timeout_cnt #(
      .TO_W     (TO_W),
      .TERMINAL (MEM_TIMEOUT - 1)
   ) u_to_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .clr   (~in_wait | mem_ack_i),
      .en    (in_wait & ~mem_ack_i),
      .tc    (to_tc)
   );

`ifdef PIPE_STALL_CNT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         stall_cnt_o <= '0;
      else if (pc_stall_o && (stall_cnt_o != '1))
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
   end
`endif

endmodule
